cdc_hs_arbiter: RTL and testbench

- Source-side scheduler that shares one four-phase req/ack clock-domain-crossing channel among N local requesters.
- Arbitrates round-robin and latches the winner's payload. Drives a level request across the boundary, then waits for the far side's acknowledge, which passes through an internal 2-flop synchronizer.
- Sits in the fast local domain, in front of the level synchronizer on the far side.

---
 rtl/cdc_hs_arbiter_pkg.sv | 12 +
 rtl/cdc_hs_arbiter_sync_2ff.sv | 22 ++
 rtl/cdc_hs_arbiter.sv | 149 ++++++++++++++
 tb/tb_cdc_hs_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_arbiter_pkg.sv
// Shared constants for the req/ack CDC handshake arbiter.
package cdc_pkg;

  // Handshake FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  // Default payload width per requester.
  localparam int CDC_DW_DEFAULT = 32;

endpackage

// File: rtl/cdc_hs_arbiter_sync_2ff.sv
// Two-flop level synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous level through two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cdc_hs_arbiter.sv
// Round-robin scheduler sharing one four-phase req/ack CDC channel among N
// local requesters. The far-side acknowledge is brought in through sync_2ff.
// Optional build macro: CDC_HS_TIMEOUT_EN adds a per-phase timeout and the
// sticky err_o output.
//
// state | meaning
// IDLE  | no transfer; grant the next requester when ack_s is low
// REQ   | xreq_o high, waiting for the synchronized ack to rise
// REL   | xreq_o low, waiting for the synchronized ack to fall
module cdc_hs_arbiter
  import cdc_pkg::*;
#(
  parameter int N              = 4,
  parameter int DW             = CDC_DW_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  input  logic [N*DW-1:0]      data_i,
  output logic [N-1:0]         gnt_o,
  output logic                 busy_o,
  output logic                 xreq_o,
  output logic [DW-1:0]        xdata_o,
  output logic [$clog2(N)-1:0] xsel_o,
  input  logic                 xack_i,
  output logic                 done_o
`ifdef CDC_HS_TIMEOUT_EN
  ,
  output logic                 err_o
`endif
);

  localparam int PW = $clog2(N);

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          any_req;
  logic          grant_ok;
  logic          ack_s;
  int            idx;

`ifdef CDC_HS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          tmo;

  // Fires on the cycle whose edge would bring the phase count to the limit.
  assign tmo = (cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  sync_2ff u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (xack_i),
    .q   (ack_s)
  );

  // Round-robin pick: first set request searching upward from ptr+1.
  always_comb begin
    win     = ptr;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any_req && req_i[idx[PW-1:0]]) begin
        any_req = 1'b1;
        win     = idx[PW-1:0];
      end
    end
  end

  // A grant needs a quiet channel (ack_s low) and at least one request.
  assign grant_ok = (state == ST_IDLE) && !ack_s && any_req && !rst;
  assign done_o   = (state == ST_REL) && !ack_s && !rst;
  assign busy_o   = (state != ST_IDLE);

  // One-hot grant pulse in the cycle the winner's payload is captured.
  always_comb begin
    gnt_o = '0;
    if (grant_ok) gnt_o[win] = 1'b1;
  end

  // Handshake FSM with payload capture and pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= PW'(N - 1);
      xreq_o  <= 1'b0;
      xdata_o <= '0;
      xsel_o  <= '0;
`ifdef CDC_HS_TIMEOUT_EN
      cnt     <= '0;
      err_o   <= 1'b0;
`endif
    end else begin
`ifdef CDC_HS_TIMEOUT_EN
      cnt <= cnt + 1'b1;
`endif
      case (state)
        ST_IDLE: begin
`ifdef CDC_HS_TIMEOUT_EN
          cnt <= '0;
`endif
          if (grant_ok) begin
            state   <= ST_REQ;
            xreq_o  <= 1'b1;
            xdata_o <= data_i[win*DW +: DW];
            xsel_o  <= win;
            ptr     <= win;
          end
        end
        ST_REQ: begin
          // A real acknowledge wins over a timeout in the same cycle.
          if (ack_s) begin
            state  <= ST_REL;
            xreq_o <= 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
            cnt    <= '0;
          end else if (tmo) begin
            state  <= ST_IDLE;
            xreq_o <= 1'b0;
            err_o  <= 1'b1;
            cnt    <= '0;
`endif
          end
        end
        ST_REL: begin
          if (!ack_s) begin
            state <= ST_IDLE;
`ifdef CDC_HS_TIMEOUT_EN
            cnt   <= '0;
          end else if (tmo) begin
            state <= ST_IDLE;
            err_o <= 1'b1;
            cnt   <= '0;
`endif
          end
        end
        default: begin
          state  <= ST_IDLE;
          xreq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Directed self-checking bench for cdc_hs_arbiter (N=4, DW=32). The far side
// is modelled as a 3-cycle delayed echo of xreq_o, with an override for
// forcing xack_i to a fixed level.
module tb_cdc_hs_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    gnt_o;
  logic            busy_o;
  logic            xreq_o;
  logic [DW-1:0]   xdata_o;
  logic [1:0]      xsel_o;
  logic            xack_i;
  logic            done_o;
`ifdef CDC_HS_TIMEOUT_EN
  logic            err_o;
`endif

  logic [2:0]  dly = '0;
  logic        ack_ovr = 1'b0;
  logic        ack_val = 1'b0;
  logic [31:0] dat [N];

  int errors = 0;
  int checks = 0;

  cdc_hs_arbiter #(.N(N), .DW(DW), .TIMEOUT_CYCLES(15)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .data_i  (data_i),
    .gnt_o   (gnt_o),
    .busy_o  (busy_o),
    .xreq_o  (xreq_o),
    .xdata_o (xdata_o),
    .xsel_o  (xsel_o),
    .xack_i  (xack_i),
    .done_o  (done_o)
`ifdef CDC_HS_TIMEOUT_EN
    ,
    .err_o   (err_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) dly <= {dly[1:0], xreq_o};
  assign xack_i = ack_ovr ? ack_val : dly[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input int limit, output int cyc);
    #1;
    cyc = 0;
    while (gnt_o == '0 && cyc < limit) begin
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_done(input int limit, output int cyc);
    #1;
    cyc = 0;
    while (done_o !== 1'b1 && cyc < limit) begin
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    req_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full handshake for requester exp_idx; returns one cycle after done_o.
  task automatic hs(input int exp_idx, input int exp_gap, input string tag);
    int cyc;
    wait_gnt(40, cyc);
    chk({tag, "_gnt"}, 32'(gnt_o), 32'(1) << exp_idx);
    if (exp_gap >= 0) chk({tag, "_gap"}, cyc, exp_gap);
    @(negedge clk); #1;
    chk({tag, "_xreq"}, 32'(xreq_o), 1);
    chk({tag, "_xsel"}, 32'(xsel_o), exp_idx);
    chk({tag, "_xdata"}, xdata_o, dat[exp_idx]);
    wait_done(40, cyc);
    chk({tag, "_done"}, 32'(done_o), 1);
    @(negedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the directed sequence finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int done_cnt;
    int done_at;
    int bad;

    dat[0] = 32'hDEAD_BEEF;
    dat[1] = 32'h1111_1111;
    dat[2] = 32'h2222_2222;
    dat[3] = 32'h3333_3333;
    data_i = {dat[3], dat[2], dat[1], dat[0]};
    rst    = 1'b1;
    req_i  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt",   32'(gnt_o),   0);
    chk("rst_busy",  32'(busy_o),  0);
    chk("rst_xreq",  32'(xreq_o),  0);
    chk("rst_xdata", xdata_o,      0);
    chk("rst_xsel",  32'(xsel_o),  0);
    chk("rst_done",  32'(done_o),  0);
    rst = 1'b0;

    // Single request, far side delay 3: done_o 12 cycles after gnt_o
    @(negedge clk);
    req_i = 4'b0001;
    #1;
    chk("t1_gnt", 32'(gnt_o), 1);
    done_cnt = 0;
    done_at  = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        chk("t1_xreq",  32'(xreq_o), 1);
        chk("t1_xdata", xdata_o, 32'hDEAD_BEEF);
        chk("t1_xsel",  32'(xsel_o), 0);
        chk("t1_gnt_pulse", 32'(gnt_o), 0);
        req_i = '0;
      end
      if (done_o === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
    chk("t1_done_at",  done_at, 12);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_after", 32'(busy_o), 0);

    // All four requesting: order 0,1,2,3,0, each grant right after done_o
    do_reset();
    req_i = 4'b1111;
    hs(0, -1, "t2_a");
    hs(1, 0, "t2_b");
    hs(2, 0, "t2_c");
    hs(3, 0, "t2_d");
    hs(0, 0, "t2_e");

    // Pointer at 1, requests 1010: grant 3 then 1
    hs(1, 0, "t3_pre");
    req_i = 4'b1010;
    hs(3, 0, "t3_a");
    hs(1, 0, "t3_b");
    req_i = '0;

    // xack_i held high: no grant until it falls, then 2..3 cycles
    ack_ovr = 1'b1;
    ack_val = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    req_i = 4'b0001;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (gnt_o != '0) bad++;
      @(negedge clk);
    end
    chk("t4_no_grant", bad, 0);
    ack_val = 1'b0;
    wait_gnt(6, cyc);
    chk("t4_gnt", 32'(gnt_o), 1);
    chk("t4_latency_ok", 32'(cyc >= 2 && cyc <= 3), 1);
    ack_ovr = 1'b0;
    @(negedge clk);
    req_i = '0;
    wait_done(40, cyc);
    chk("t4_done", 32'(done_o), 1);
    @(negedge clk);

    // Reset in REQ abandons the transfer and resets the pointer
    req_i = 4'b0001;
    wait_gnt(10, cyc);
    chk("t5_gnt0", 32'(gnt_o), 1);
    @(negedge clk); #1;
    chk("t5_in_req", 32'(xreq_o), 1);
    rst   = 1'b1;
    req_i = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_xreq", 32'(xreq_o), 0);
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_gnt",  32'(gnt_o),  0);
    repeat (10) @(negedge clk);
    req_i = 4'b0011;
    wait_gnt(5, cyc);
    chk("t5_ptr_reset", 32'(gnt_o), 1);
    @(negedge clk);
    req_i = '0;
    wait_done(40, cyc);
    chk("t5_done", 32'(done_o), 1);
    @(negedge clk);

`ifdef CDC_HS_TIMEOUT_EN
    // Timeout with xack_i tied low: xreq_o high for 15 cycles, sticky err_o
    ack_ovr = 1'b1;
    ack_val = 1'b0;
    #1;
    chk("t6_err_init", 32'(err_o), 0);
    req_i = 4'b0001;
    wait_gnt(5, cyc);
    chk("t6_gnt", 32'(gnt_o), 1);
    done_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      if (c == 1) req_i = '0;
      if (c == 15) chk("t6_xreq_still_high", 32'(xreq_o), 1);
      if (c == 16) begin
        chk("t6_xreq_fell", 32'(xreq_o), 0);
        chk("t6_err_set",   32'(err_o),  1);
        chk("t6_busy",      32'(busy_o), 0);
      end
      if (done_o === 1'b1) done_cnt++;
    end
    chk("t6_no_done", done_cnt, 0);
    ack_ovr = 1'b0;
    @(negedge clk);
    req_i = 4'b0100;
    hs(2, -1, "t6_next");
    req_i = '0;
    chk("t6_err_sticky", 32'(err_o), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
